// File: rtl/vram_sched_pkg.sv
// Shared types and address helper for the VRAM write scheduler.
package vram_sched_pkg;

  typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_e;
  typedef enum logic {GRANT_DRAW, GRANT_HOST} grant_e;

  // Signed offset width used by the stamp iterator; covers radius up to 7.
  localparam int unsigned STAMP_DW = 5;

  function automatic logic [31:0] xy_to_addr(input logic [31:0] x, input logic [31:0] y,
                                             input logic [31:0] width);
    return y * width + x;
  endfunction

endpackage

// File: rtl/vram_write_scheduler_stamp_iterator.sv
// Walks the square brush footprint row by row: dy outer, dx inner, both -R..R.
module stamp_iterator
  import vram_sched_pkg::*;
#(
  parameter int unsigned BRUSH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       advance,
  output logic signed [STAMP_DW-1:0] dx,
  output logic signed [STAMP_DW-1:0] dy,
  output logic                       last
);

  localparam int unsigned R = (BRUSH - 1) / 2;
  localparam logic signed [STAMP_DW-1:0] R_POS = STAMP_DW'(R);
  localparam logic signed [STAMP_DW-1:0] R_NEG = -R_POS;

  logic signed [STAMP_DW-1:0] dx_q, dx_d, dy_q, dy_d;

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (start) begin
      dx_d = R_NEG;
      dy_d = R_NEG;
    end else if (advance) begin
      if (dx_q == R_POS) begin
        dx_d = R_NEG;
        dy_d = dy_q + STAMP_DW'(1);
      end else begin
        dx_d = dx_q + STAMP_DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dx_q <= R_NEG;
      dy_q <= R_NEG;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx   = dx_q;
  assign dy   = dy_q;
  assign last = (dx_q == R_POS) && (dy_q == R_POS);

endmodule

// File: rtl/vram_write_scheduler.sv
// Arbitrates the single VRAM write port between clear engine, brush stamper and host writer.
// Optional: define VRAM_STAMP_DEDUP_EN to skip a draw identical to the last completed stamp.
module vram_write_scheduler
  import vram_sched_pkg::*;
#(
  parameter int unsigned DISPLAY_WIDTH  = 240,
  parameter int unsigned DISPLAY_HEIGHT = 320,
  parameter int unsigned VRAM_W         = 16,
  parameter int unsigned BRUSH          = 3,
  parameter logic [VRAM_W-1:0] CLEAR_COLOR = VRAM_W'(16'h000F),
  localparam int unsigned L = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  localparam int unsigned A = $clog2(L),
  localparam int unsigned C = $clog2(DISPLAY_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic              draw_valid,
  output logic              draw_ready,
  input  logic [C-1:0]      draw_x,
  input  logic [C-1:0]      draw_y,
  input  logic [VRAM_W-1:0] draw_color,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [A-1:0]      host_addr,
  input  logic [VRAM_W-1:0] host_data,
  output logic              vram_wr_ena,
  output logic [A-1:0]      vram_wr_addr,
  output logic [VRAM_W-1:0] vram_wr_data,
  output logic              busy,
  output logic              clearing
);

  state_e state_q, state_d;
  grant_e last_grant_q, last_grant_d;
  logic [A-1:0]      cnt_q, cnt_d;
  logic [C-1:0]      x_q, x_d, y_q, y_d;
  logic [VRAM_W-1:0] color_q, color_d;
  logic              wr_ena_q, wr_ena_d;
  logic [A-1:0]      wr_addr_q, wr_addr_d;
  logic [VRAM_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d, clearing_q, clearing_d;

  logic                       it_start, it_advance, it_last;
  logic signed [STAMP_DW-1:0] it_dx, it_dy;
  logic signed [C:0]          px, py;
  logic                       pt_inside, host_in_range, idle, dedup_hit;
  logic [A-1:0]               pt_addr;

  stamp_iterator #(.BRUSH(BRUSH)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (it_start),
    .advance (it_advance),
    .dx      (it_dx),
    .dy      (it_dy),
    .last    (it_last)
  );

  // Current stamp point, signed so points left of/above the screen are rejected.
  assign px = $signed({1'b0, x_q}) + (C+1)'(it_dx);
  assign py = $signed({1'b0, y_q}) + (C+1)'(it_dy);
  assign pt_inside = !px[C] && !py[C] &&
                     ($unsigned(px) < (C+1)'(DISPLAY_WIDTH)) &&
                     ($unsigned(py) < (C+1)'(DISPLAY_HEIGHT));
  assign pt_addr = A'(xy_to_addr(32'($unsigned(px)), 32'($unsigned(py)), DISPLAY_WIDTH));

  assign host_in_range = 32'(host_addr) < L;

  // Round-robin: when both ask, the side that did not win last time goes first.
  assign idle       = (state_q == IDLE);
  assign host_ready = idle && !clear_req && host_valid &&
                      (!draw_valid || (last_grant_q == GRANT_DRAW));
  assign draw_ready = idle && !clear_req && draw_valid &&
                      (!host_valid || (last_grant_q == GRANT_HOST));

`ifdef VRAM_STAMP_DEDUP_EN
  logic              rec_valid_q, rec_valid_d;
  logic [C-1:0]      rec_x_q, rec_x_d, rec_y_q, rec_y_d;
  logic [VRAM_W-1:0] rec_color_q, rec_color_d;
  logic              stamp_done;

  assign stamp_done = (state_q == STAMP) && !clear_req && it_last;
  assign dedup_hit  = rec_valid_q && (draw_x == rec_x_q) && (draw_y == rec_y_q) &&
                      (draw_color == rec_color_q);

  // Record only completed stamps; any clear makes the record stale.
  always_comb begin
    rec_valid_d = rec_valid_q;
    rec_x_d     = rec_x_q;
    rec_y_d     = rec_y_q;
    rec_color_d = rec_color_q;
    if (state_q == CLEAR || state_d == CLEAR) begin
      rec_valid_d = 1'b0;
    end else if (stamp_done) begin
      rec_valid_d = 1'b1;
      rec_x_d     = x_q;
      rec_y_d     = y_q;
      rec_color_d = color_q;
    end
  end
`else
  assign dedup_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    color_d      = color_q;
    wr_ena_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    it_start     = 1'b0;
    it_advance   = 1'b0;
    unique case (state_q)
      CLEAR: begin
        wr_ena_d  = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = CLEAR_COLOR;
        if (clear_req) begin
          cnt_d = '0;
        end else if (cnt_q == A'(L - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + A'(1);
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (host_ready) begin
          wr_ena_d     = host_in_range;
          wr_addr_d    = host_addr;
          wr_data_d    = host_data;
          last_grant_d = GRANT_HOST;
        end else if (draw_ready) begin
          last_grant_d = GRANT_DRAW;
          x_d          = draw_x;
          y_d          = draw_y;
          color_d      = draw_color;
          if (!dedup_hit) begin
            state_d  = STAMP;
            it_start = 1'b1;
          end
        end
      end
      STAMP: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          wr_ena_d   = pt_inside;
          wr_addr_d  = pt_addr;
          wr_data_d  = color_q;
          it_advance = 1'b1;
          if (it_last) state_d = IDLE;
        end
      end
      default: state_d = CLEAR;
    endcase
    busy_d     = (state_d != IDLE);
    clearing_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      last_grant_q <= GRANT_HOST;
      cnt_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= '0;
      wr_ena_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b1;
      clearing_q   <= 1'b1;
`ifdef VRAM_STAMP_DEDUP_EN
      rec_valid_q  <= 1'b0;
      rec_x_q      <= '0;
      rec_y_q      <= '0;
      rec_color_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      color_q      <= color_d;
      wr_ena_q     <= wr_ena_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      clearing_q   <= clearing_d;
`ifdef VRAM_STAMP_DEDUP_EN
      rec_valid_q  <= rec_valid_d;
      rec_x_q      <= rec_x_d;
      rec_y_q      <= rec_y_d;
      rec_color_q  <= rec_color_d;
`endif
    end
  end

  assign vram_wr_ena  = wr_ena_q;
  assign vram_wr_addr = wr_addr_q;
  assign vram_wr_data = wr_data_q;
  assign busy         = busy_q;
  assign clearing     = clearing_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Bench for vram_write_scheduler: cycle model of the port rules plus directed literal checks.
module tb_vram_write_scheduler;

  localparam int W = 240;
  localparam int H = 320;
  localparam int L = W * H;
  localparam int B = 3;
  localparam int R = 1;
`ifdef VRAM_STAMP_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clear_req, draw_valid, host_valid;
  logic        draw_ready, host_ready;
  logic [8:0]  draw_x, draw_y;
  logic [15:0] draw_color, host_data;
  logic [16:0] host_addr;
  logic        vram_wr_ena, busy, clearing;
  logic [16:0] vram_wr_addr;
  logic [15:0] vram_wr_data;

  vram_write_scheduler dut (
    .clk(clk), .rst(rst), .clear_req(clear_req),
    .draw_valid(draw_valid), .draw_ready(draw_ready),
    .draw_x(draw_x), .draw_y(draw_y), .draw_color(draw_color),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_data(host_data),
    .vram_wr_ena(vram_wr_ena), .vram_wr_addr(vram_wr_addr), .vram_wr_data(vram_wr_data),
    .busy(busy), .clearing(clearing)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {int addr; logic [15:0] data;} wr_t;
  wr_t wq[$];

  // Reference model: mode, clear index, and flat stamp point index k (row = k / B).
  typedef enum int {M_IDLE, M_STAMP, M_CLEAR} mmode_t;
  mmode_t m_mode;
  int m_idx, m_k, m_x, m_y, m_rx, m_ry;
  logic [15:0] m_col, m_rc;
  bit m_lg_draw, m_rec_v, mvalid = 1'b0;
  bit e_ena, m_hr, m_dr;
  int e_addr;
  logic [15:0] e_data;

  always @(negedge clk) begin
    m_hr = (m_mode == M_IDLE) && !clear_req && host_valid && (!draw_valid || m_lg_draw);
    m_dr = (m_mode == M_IDLE) && !clear_req && draw_valid && (!host_valid || !m_lg_draw);
    if (mvalid) begin
      chk("m_host_ready", 32'(host_ready), 32'(m_hr));
      chk("m_draw_ready", 32'(draw_ready), 32'(m_dr));
      chk("m_busy", 32'(busy), 32'(m_mode != M_IDLE));
      chk("m_clearing", 32'(clearing), 32'(m_mode == M_CLEAR));
      chk("m_wr_ena", 32'(vram_wr_ena), 32'(e_ena));
      if (e_ena) begin
        chk("m_wr_addr", 32'(vram_wr_addr), 32'(e_addr));
        chk("m_wr_data", 32'(vram_wr_data), 32'(e_data));
      end
    end
    if (vram_wr_ena === 1'b1) wq.push_back('{int'(vram_wr_addr), vram_wr_data});
    if (rst) begin
      mvalid = 1'b1; m_mode = M_CLEAR; m_idx = 0; m_lg_draw = 1'b0; m_rec_v = 1'b0;
      e_ena = 1'b0;
    end else if (mvalid) begin
      e_ena = 1'b0;
      case (m_mode)
        M_CLEAR: begin
          e_ena = 1'b1; e_addr = m_idx; e_data = 16'h000F; m_rec_v = 1'b0;
          if (clear_req) m_idx = 0;
          else if (m_idx == L - 1) m_mode = M_IDLE;
          else m_idx++;
        end
        M_IDLE: begin
          if (clear_req) begin
            m_mode = M_CLEAR; m_idx = 0; m_rec_v = 1'b0;
          end else if (m_hr) begin
            e_ena = int'(host_addr) < L; e_addr = int'(host_addr); e_data = host_data;
            m_lg_draw = 1'b0;
          end else if (m_dr) begin
            m_lg_draw = 1'b1;
            if (!(DEDUP && m_rec_v && int'(draw_x) == m_rx && int'(draw_y) == m_ry &&
                  draw_color == m_rc)) begin
              m_mode = M_STAMP; m_k = 0;
              m_x = int'(draw_x); m_y = int'(draw_y); m_col = draw_color;
            end
          end
        end
        default: begin
          if (clear_req) begin
            m_mode = M_CLEAR; m_idx = 0; m_rec_v = 1'b0;
          end else begin
            int px, py;
            px = m_x + (m_k % B) - R;
            py = m_y + (m_k / B) - R;
            if (px >= 0 && px < W && py >= 0 && py < H) begin
              e_ena = 1'b1; e_addr = py * W + px; e_data = m_col;
            end
            if (m_k == B * B - 1) begin
              m_mode = M_IDLE; m_rec_v = 1'b1; m_rx = m_x; m_ry = m_y; m_rc = m_col;
            end else m_k++;
          end
        end
      endcase
    end
  end

  task automatic do_draw(input int x, input int y, input logic [15:0] c, output int stamp_cyc);
    int n;
    draw_x = 9'(x); draw_y = 9'(y); draw_color = c; draw_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (draw_ready !== 1'b1 && n < 20);
    chk("draw_accept", 32'(draw_ready), 32'd1);
    @(posedge clk); #1; draw_valid = 1'b0;
    stamp_cyc = 0;
    while (busy === 1'b1 && stamp_cyc < 40) begin stamp_cyc++; @(posedge clk); #1; end
  endtask

  task automatic chk_log4(input string nm, input int base, input int a0, input int a1,
                          input int a2, input int a3, input logic [15:0] d);
    int exp_a[4];
    exp_a = '{a0, a1, a2, a3};
    chk({nm, "_count"}, 32'(wq.size() - base), 32'd4);
    if (wq.size() - base == 4)
      for (int i = 0; i < 4; i++) begin
        chk({nm, "_addr"}, 32'(wq[base+i].addr), 32'(exp_a[i]));
        chk({nm, "_data"}, 32'(wq[base+i].data), 32'(d));
      end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, base, sc, sc2, bad;
    rst = 1'b1; clear_req = 1'b0;
    draw_valid = 1'b1; draw_x = '0; draw_y = '0; draw_color = '0;
    host_valid = 1'b1; host_addr = 17'd5; host_data = 16'h5555;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ena", 32'(vram_wr_ena), 32'd0);
    chk("rst_wr_addr", 32'(vram_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(vram_wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_clearing", 32'(clearing), 32'd1);
    chk("rst_host_ready", 32'(host_ready), 32'd0);
    chk("rst_draw_ready", 32'(draw_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; host_valid = 1'b0; draw_valid = 1'b0;
    base = wq.size();

    // Power-up clear: every address once, in order, then idle.
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 80000) begin n++; @(negedge clk); end
    chk("clear_busy_cycles", 32'(n), 32'd76800);
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    chk("clear_writes", 32'(wq.size() - base), 32'd76800);
    bad = 0;
    for (int i = 0; i < wq.size() - base; i++)
      if (wq[base+i].addr != i || wq[base+i].data != 16'h000F) bad++;
    chk("clear_order", 32'(bad), 32'd0);

    // Corner stamps clipped to the screen.
    base = wq.size();
    do_draw(0, 0, 16'hFD20, sc);
    repeat (2) begin @(posedge clk); #1; end
    chk("stamp00_cycles", 32'(sc), 32'd9);
    chk_log4("stamp00", base, 0, 1, 240, 241, 16'hFD20);

    base = wq.size();
    do_draw(239, 319, 16'h07E0, sc);
    repeat (2) begin @(posedge clk); #1; end
    chk("stamp_br_cycles", 32'(sc), 32'd9);
    chk_log4("stamp_br", base, 76558, 76559, 76798, 76799, 16'h07E0);

    // Both requesters with last grant = draw: host first, then draw.
    host_addr = 17'd100; host_data = 16'h1234; host_valid = 1'b1;
    draw_x = 9'd5; draw_y = 9'd5; draw_color = 16'hF800; draw_valid = 1'b1;
    @(negedge clk);
    chk("rr_host_ready", 32'(host_ready), 32'd1);
    chk("rr_draw_wait", 32'(draw_ready), 32'd0);
    @(posedge clk); #1; host_valid = 1'b0;
    @(negedge clk);
    chk("rr_draw_ready", 32'(draw_ready), 32'd1);
    chk("rr_host_ena", 32'(vram_wr_ena), 32'd1);
    chk("rr_host_addr", 32'(vram_wr_addr), 32'd100);
    chk("rr_host_data", 32'(vram_wr_data), 32'h1234);
    @(posedge clk); #1; draw_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; @(posedge clk); #1; end
    chk("rr_stamp_cycles", 32'(n), 32'd9);
    repeat (2) begin @(posedge clk); #1; end

    // Host writes back-to-back around the top of the address range.
    base = wq.size();
    host_valid = 1'b1; host_addr = 17'd76799; host_data = 16'hAAAA;
    @(negedge clk); chk("host_last_ready", 32'(host_ready), 32'd1);
    @(posedge clk); #1; host_addr = 17'd76800;
    @(negedge clk);
    chk("host_oob_ready", 32'(host_ready), 32'd1);
    chk("host_last_ena", 32'(vram_wr_ena), 32'd1);
    chk("host_last_addr", 32'(vram_wr_addr), 32'd76799);
    @(posedge clk); #1; host_addr = 17'd80000;
    @(negedge clk);
    chk("host_80000_ready", 32'(host_ready), 32'd1);
    chk("host_oob_ena", 32'(vram_wr_ena), 32'd0);
    @(posedge clk); #1; host_valid = 1'b0;
    @(negedge clk); chk("host_80000_ena", 32'(vram_wr_ena), 32'd0);
    @(posedge clk); #1;
    chk("host_writes", 32'(wq.size() - base), 32'd1);

    // Identical stamps back-to-back.
    base = wq.size();
    do_draw(10, 10, 16'hFD20, sc);
    do_draw(10, 10, 16'hFD20, sc2);
    repeat (2) begin @(posedge clk); #1; end
    chk("dup_first_cycles", 32'(sc), 32'd9);
    chk("dup_second_cycles", 32'(sc2), DEDUP ? 32'd0 : 32'd9);
    chk("dup_writes", 32'(wq.size() - base), DEDUP ? 32'd9 : 32'd18);

    // Clear request on the 4th stamp cycle aborts the stamp.
    base = wq.size();
    draw_x = 9'd100; draw_y = 9'd100; draw_color = 16'h07E0; draw_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (draw_ready !== 1'b1 && n < 20);
    chk("abort_accept", 32'(draw_ready), 32'd1);
    @(posedge clk); #1; draw_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    clear_req = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_not_clearing", 32'(clearing), 32'd0);
    @(posedge clk); #1; clear_req = 1'b0;
    @(negedge clk);
    chk("abort_no_write", 32'(vram_wr_ena), 32'd0);
    chk("abort_clearing", 32'(clearing), 32'd1);
    repeat (4) begin @(posedge clk); #1; end
    chk("abort_log_len", 32'(wq.size() - base >= 5), 32'd1);
    if (wq.size() - base >= 5) begin
      chk("abort_p0", 32'(wq[base].addr), 32'd23859);
      chk("abort_p1", 32'(wq[base+1].addr), 32'd23860);
      chk("abort_p2", 32'(wq[base+2].addr), 32'd23861);
      chk("abort_p_data", 32'(wq[base+2].data), 32'h07E0);
      chk("abort_clr0_addr", 32'(wq[base+3].addr), 32'd0);
      chk("abort_clr0_data", 32'(wq[base+3].data), 32'h000F);
      chk("abort_clr1_addr", 32'(wq[base+4].addr), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vram_write_scheduler.md
Name: vram_write_scheduler

Overview:
- Owns the single write port of the VRAM block_ram (W=16, L=DISPLAY_WIDTH*DISPLAY_HEIGHT).
- Shares the port between three requesters:
  - full-screen clear engine;
  - brush-stamp drawing requester, fed from touch0;
  - single-pixel host/debug writer.
- Sits between the touch/UI logic and VRAM in main. Replaces the ad-hoc IDLE/DRAWING/CLEAR FSM.

Parameters:
- DISPLAY_WIDTH, 240, pixels per row.
- DISPLAY_HEIGHT, 320, rows.
- VRAM_W, 16, pixel width (RGB565).
- BRUSH, 3, odd side length of the square stamp, 1..15.
- CLEAR_COLOR, 16'h000F, background (NAVY).
- Derived localparams (not overridable): L=DISPLAY_WIDTH*DISPLAY_HEIGHT; A=$clog2(L); C=$clog2(DISPLAY_HEIGHT); R=(BRUSH-1)/2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- clear_req  in  1  single-cycle clear request.
- draw_valid  in  1  stamp request valid.
- draw_ready  out  1  stamp request accepted when high with draw_valid.
- draw_x  in  C  stamp centre column (unsigned).
- draw_y  in  C  stamp centre row (unsigned).
- draw_color  in  VRAM_W  stamp colour.
- host_valid  in  1  pixel write valid.
- host_ready  out  1  pixel write accepted.
- host_addr  in  A  linear pixel address.
- host_data  in  VRAM_W  pixel data.
- vram_wr_ena  out  1  VRAM write enable.
- vram_wr_addr  out  A  VRAM write address.
- vram_wr_data  out  VRAM_W  VRAM write data.
- busy  out  1  high in CLEAR or STAMP.
- clearing  out  1  high in CLEAR.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - state=CLEAR, clear counter=0;
  - vram_wr_ena=0, vram_wr_addr=0, vram_wr_data=0;
  - draw_ready=host_ready=0;
  - busy=1, clearing=1;
  - last_grant=HOST.
- Output timing:
  - vram_wr_* are registered.
  - A write decided in cycle t appears on the port in cycle t+1.
  - draw_ready and host_ready are combinational from state, clear_req, valids and last_grant.
- Handshakes: transfer occurs on valid&&ready. Requesters hold valid and payload stable until the transfer.
- CLEAR state:
  - One write per cycle: addr=counter, data=CLEAR_COLOR, counter 0..L-1.
  - Exactly L writes; address L is never written.
  - After issuing addr L-1, go to IDLE.
  - clear_req during CLEAR restarts the counter at 0.
  - Both readies are 0.
- IDLE state, priority in order:
  1. clear_req: go to CLEAR, counter=0; neither requester is accepted that cycle.
  2. Only one of draw_valid/host_valid high: that requester is granted.
  3. Both high: grant the one that is not last_grant (round-robin).
- Host grant:
  - Next cycle: wr_ena=1, addr=host_addr, data=host_data.
  - If host_addr>=L: wr_ena=0, but the request is still accepted.
  - Stays in IDLE; throughput 1 write/cycle.
  - last_grant=HOST.
- Draw grant:
  - Capture x, y, color; go to STAMP; last_grant=DRAW.
- STAMP state:
  - Iterates dy=-R..R (outer), dx=-R..R (inner): BRUSH² cycles, one per point.
  - Point px=x+dx, py=y+dy, computed signed at width C+1.
  - If 0<=px<DISPLAY_WIDTH and 0<=py<DISPLAY_HEIGHT: write addr=py*DISPLAY_WIDTH+px (computed at width A), data=color.
  - Otherwise the cycle has wr_ena=0.
  - After the last point, go to IDLE.
  - Readies are 0 in STAMP.
- clear_req during STAMP: stamp aborts immediately (current point not written). Next cycle enters CLEAR at counter 0.
- Stamp latency: accept at t, first write at t+1, last write at t+BRUSH², draw_ready can re-assert at t+BRUSH²+1.
- Reset mid-operation: returns to CLEAR at counter 0 regardless of state.

Optional Feature:
- Macro: VRAM_STAMP_DEDUP_EN.
- Defined:
  - Module keeps last stamped (x,y,color); reset clears this record as invalid.
  - An accepted draw whose x, y and color equal the last completed stamp performs no writes and stays in IDLE (consumes the accept cycle only).
  - An aborted stamp does not update the record.
  - CLEAR invalidates the record.
- Not defined: every accepted draw runs a full STAMP.

Decomposition:
- Package vram_sched_pkg:
  - state enum {IDLE, STAMP, CLEAR};
  - grant enum {GRANT_DRAW, GRANT_HOST};
  - helper function xy_to_addr.
- Colour constants stay in ili9341_defines.
- Sub-module stamp_iterator (BRUSH param): start/advance in; signed dx, dy and last out.

Test Plan:
- Reset, BRUSH=3 → exactly 76800 writes, addr 0..76799 in order, data 16'h000F; busy falls the cycle after addr 76799; addr 76800 never written.
- After clear, draw (0,0) color 16'hFD20 → 9 STAMP cycles; writes only, in order, addr 0, 1, 240, 241.
- Draw (239,319) → writes, in order, 76558, 76559, 76798, 76799; other 5 cycles wr_ena=0.
- In IDLE with last_grant=DRAW, host_valid(addr 100, data 16'h1234) and draw_valid asserted together → host accepted first, write at addr 100 next cycle, draw accepted the following cycle.
- clear_req on 4th STAMP cycle → no further stamp writes, next cycle writes addr 0 with 16'h000F; host_addr 80000 → accepted, wr_ena stays 0.
- With VRAM_STAMP_DEDUP_EN, two identical draws (10,10,16'hFD20) back-to-back → 9 writes total; without the macro → 18 writes.
